// File: rtl/ts_packet_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ts_packet_tx_if
// Brief    : Payload input handshake and TS byte output bundle for ts_packet_tx
// Revision : 1.0
// ============================================================================
interface ts_packet_tx_if;
  logic [7:0] in_byte;
  logic       in_start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sop;
  logic       null_pkt;

  modport master (
    output in_byte, in_start, in_valid,
    input  in_ready, byte_out, byte_valid, sop, null_pkt
  );

  modport slave (
    input  in_byte, in_start, in_valid,
    output in_ready, byte_out, byte_valid, sop, null_pkt
  );
endinterface
`default_nettype wire

// File: rtl/ts_packet_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ts_packet_tx
// Brief    : MPEG2-TS packetiser with payload FIFO and null-packet stuffing
// Revision : 1.0
// ============================================================================
module ts_packet_tx #(
  parameter logic [12:0] PID        = 13'h0100,
  parameter int          FIFO_DEPTH = 512,
  parameter bit          NULL_EN    = 1'b1
) (
  input  wire                          clk,
  input  wire                          rst,
  input  wire                          tx_en,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  ts_packet_tx_if.slave                bus
);

  localparam int                  c_ADDR_W      = $clog2(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0]   c_LVL_FULL    = (c_ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [c_ADDR_W:0]   c_LVL_PAYLOAD = (c_ADDR_W+1)'(184);
  localparam logic [c_ADDR_W:0]   c_LVL_ONE     = (c_ADDR_W+1)'(1);
  localparam logic [c_ADDR_W-1:0] c_PTR_ONE     = c_ADDR_W'(1);
  localparam logic [7:0]          c_SYNC        = 8'h47;
  localparam logic [7:0]          c_LAST        = 8'd187;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_NULL = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [8:0]            r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]   r_wptr, r_rptr;
  logic [c_ADDR_W:0]     r_level;
  logic [7:0]            r_bcnt, w_bcnt_nxt;
  logic                  r_is_null, w_is_null_nxt;
  logic [3:0]            r_cc, w_cc_nxt;
  logic                  w_emit, w_sop, w_pop, w_push, w_null_pkt_nxt;
  logic [7:0]            w_byte;
  logic [8:0]            w_head;
  logic [7:0]            r_byte_out;
  logic                  r_byte_valid, r_sop, r_null_pkt;

  assign w_head       = r_mem[r_rptr];
  assign bus.in_ready = rst && (r_level < c_LVL_FULL);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign fifo_level   = r_level;

  // Payload storage: {in_start, in_byte}; no reset needed on the array itself
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.in_start, bus.in_byte};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + c_LVL_ONE;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - c_LVL_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_is_null <= 1'b0;
      r_cc      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_is_null <= w_is_null_nxt;
      r_cc      <= w_cc_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bcnt_nxt    = r_bcnt;
    w_is_null_nxt = r_is_null;
    w_cc_nxt      = r_cc;
    w_emit        = 1'b0;
    w_sop         = 1'b0;
    w_pop         = 1'b0;
    w_byte        = 8'h00;
    if (tx_en) begin
      case (r_state)
        S_IDLE: begin
          // Packet type is fixed here for the whole 188 bytes
          if ((r_level >= c_LVL_PAYLOAD) || NULL_EN) begin
            w_is_null_nxt = (r_level < c_LVL_PAYLOAD);
            w_emit        = 1'b1;
            w_sop         = 1'b1;
            w_byte        = c_SYNC;
            w_bcnt_nxt    = 8'd1;
            w_state_nxt   = S_HDR;
          end
        end
        S_HDR: begin
          w_emit     = 1'b1;
          w_bcnt_nxt = r_bcnt + 8'd1;
          case (r_bcnt)
            8'd1:    w_byte = r_is_null ? 8'h1F : {1'b0, w_head[8], 1'b0, PID[12:8]};
            8'd2:    w_byte = r_is_null ? 8'hFF : PID[7:0];
            default: begin
              w_byte      = r_is_null ? 8'h10 : {4'b0001, r_cc};
              w_state_nxt = r_is_null ? S_NULL : S_DATA;
            end
          endcase
        end
        S_DATA, S_NULL: begin
          w_emit = 1'b1;
          w_pop  = (r_state == S_DATA);
          w_byte = (r_state == S_DATA) ? w_head[7:0] : 8'hFF;
          if (r_bcnt == c_LAST) begin
            w_bcnt_nxt  = 8'd0;
            w_state_nxt = S_IDLE;
            if (r_state == S_DATA) begin
              w_cc_nxt = r_cc + 4'd1;
            end
          end else begin
            w_bcnt_nxt = r_bcnt + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // null_pkt holds across tx_en gaps until the last byte of the packet
  assign w_null_pkt_nxt = w_emit ? w_is_null_nxt : ((r_state != S_IDLE) && r_is_null);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_sop        <= 1'b0;
      r_null_pkt   <= 1'b0;
    end else begin
      r_byte_out   <= w_emit ? w_byte : 8'h00;
      r_byte_valid <= w_emit;
      r_sop        <= w_sop;
      r_null_pkt   <= w_null_pkt_nxt;
    end
  end

  assign bus.byte_out   = r_byte_out;
  assign bus.byte_valid = r_byte_valid;
  assign bus.sop        = r_sop;
  assign bus.null_pkt   = r_null_pkt;

endmodule
`default_nettype wire

// File: tb/tb_ts_packet_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ts_packet_tx
// Brief    : Self-checking bench for ts_packet_tx (packet-level model + directed)
// Revision : 1.0
// ============================================================================
module tb_ts_packet_tx;
  localparam int          DEPTH = 512;
  localparam logic [12:0] TPID  = 13'h0100;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       tx_en  = 1'b0;
  logic       tx_en2 = 1'b0;
  logic [9:0] level, level2;

  ts_packet_tx_if bus();
  ts_packet_tx_if bus2();

  ts_packet_tx #(.PID(TPID), .FIFO_DEPTH(DEPTH), .NULL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_level(level), .bus(bus.slave)
  );

  ts_packet_tx #(.PID(TPID), .FIFO_DEPTH(DEPTH), .NULL_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_level(level2), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model (dut, NULL_EN=1) ----------
  logic [8:0] mq[$];
  bit         m_in_pkt = 0, m_null = 0;
  int         m_idx = 0, m_cc = 0;
  logic [7:0] m_pkt [188];
  logic [7:0] e_byte = 8'h00;
  bit         e_valid = 0, e_sop = 0, e_null = 0;

  always @(posedge clk or negedge rst) begin : model
    bit push, emit;
    if (!rst) begin
      mq.delete();
      m_in_pkt = 0; m_null = 0; m_idx = 0; m_cc = 0;
      e_byte = 8'h00; e_valid = 0; e_sop = 0; e_null = 0;
    end else begin
      push = bus.in_valid && (mq.size() < DEPTH);
      emit = 0;
      if (tx_en) begin
        if (!m_in_pkt) begin
          m_pkt[0] = 8'h47;
          if (mq.size() >= 184) begin
            m_null   = 0;
            m_pkt[1] = {1'b0, mq[0][8], 1'b0, TPID[12:8]};
            m_pkt[2] = TPID[7:0];
            m_pkt[3] = 8'h10 | 8'(m_cc);
            for (int i = 0; i < 184; i++) m_pkt[4+i] = mq[i][7:0];
          end else begin
            m_null   = 1;
            m_pkt[1] = 8'h1F; m_pkt[2] = 8'hFF; m_pkt[3] = 8'h10;
            for (int i = 4; i < 188; i++) m_pkt[i] = 8'hFF;
          end
          m_in_pkt = 1;
          m_idx    = 0;
        end
        emit   = 1;
        e_byte = m_pkt[m_idx];
        e_sop  = (m_idx == 0);
        if (!m_null && m_idx >= 4) void'(mq.pop_front());
        if (m_idx == 187) begin
          m_in_pkt = 0;
          if (!m_null) m_cc = (m_cc + 1) % 16;
        end else begin
          m_idx++;
        end
      end
      e_valid = emit;
      if (!emit) begin
        e_byte = 8'h00;
        e_sop  = 0;
        e_null = m_in_pkt && m_null;
      end else begin
        e_null = m_null;
      end
      if (push) mq.push_back({bus.in_start, bus.in_byte});
    end
  end

  always @(negedge clk) begin
    chk("byte_valid", 32'(bus.byte_valid), 32'(e_valid));
    chk("byte_out",   32'(bus.byte_out),   32'(e_byte));
    chk("sop",        32'(bus.sop),        32'(e_sop));
    chk("null_pkt",   32'(bus.null_pkt),   32'(e_null));
    chk("fifo_level", 32'(level),          32'(mq.size()));
    chk("in_ready",   32'(bus.in_ready),   32'(rst && (mq.size() < DEPTH)));
  end

  // ---------------- output capture ----------------
  logic [7:0] obytes[$], obytes2[$];
  bit         onull[$], osop[$];

  always @(negedge clk) begin
    if (bus.byte_valid) begin
      obytes.push_back(bus.byte_out);
      onull.push_back(bus.null_pkt);
      osop.push_back(bus.sop);
    end
    if (bus2.byte_valid) obytes2.push_back(bus2.byte_out);
  end

  task automatic clear_capture();
    obytes.delete(); onull.delete(); osop.delete(); obytes2.delete();
  endtask

  task automatic do_reset();
    tx_en = 0; tx_en2 = 0;
    bus.in_valid = 0; bus.in_start = 0; bus2.in_valid = 0; bus2.in_start = 0;
    @(negedge clk); #2 rst = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
  endtask

  task automatic push_n(input int n, input int base, input bit start_first);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < n + 2000) begin
      @(negedge clk);
      bus.in_valid = 1;
      bus.in_byte  = 8'(base + acc);
      bus.in_start = start_first && (acc == 0);
      if (bus.in_ready) acc++;
      guard++;
    end
    @(negedge clk);
    bus.in_valid = 0;
    bus.in_start = 0;
    chk("push_count", 32'(acc), 32'(n));
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (obytes.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_bytes", 32'(obytes.size() >= n), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc, guard, cnt;
    bus.in_valid = 0; bus.in_start = 0; bus.in_byte = 0;
    bus2.in_valid = 0; bus2.in_start = 0; bus2.in_byte = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst byte_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst in_ready",   32'(bus.in_ready),   32'd0);
    chk("rst level",      32'(level),          32'd0);
    #2 rst = 1;
    @(negedge clk);
    chk("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    // 1: single data packet with PUSI
    push_n(184, 0, 1);
    clear_capture();
    repeat (188) begin @(negedge clk); tx_en = 1; end
    @(negedge clk); tx_en = 0;
    repeat (2) @(negedge clk);
    chk("t1 count", 32'(obytes.size()), 32'd188);
    chk("t1 b0",  32'(obytes[0]),   32'h47);
    chk("t1 b1",  32'(obytes[1]),   32'h41);
    chk("t1 b2",  32'(obytes[2]),   32'h00);
    chk("t1 b3",  32'(obytes[3]),   32'h10);
    chk("t1 b4",  32'(obytes[4]),   32'h00);
    chk("t1 b187",32'(obytes[187]), 32'hB7);
    chk("t1 sop0",32'(osop[0]),     32'd1);
    chk("t1 sop1",32'(osop[1]),     32'd0);
    chk("t1 level", 32'(level),     32'd0);

    // 2: two data packets then null stuffing
    do_reset();
    push_n(368, 0, 0);
    clear_capture();
    @(negedge clk); tx_en = 1;
    wait_bytes(564, 800);
    tx_en = 0;
    chk("t2 p0 b1",  32'(obytes[1]),   32'h01);
    chk("t2 p0 b3",  32'(obytes[3]),   32'h10);
    chk("t2 p1 b0",  32'(obytes[188]), 32'h47);
    chk("t2 p1 b3",  32'(obytes[191]), 32'h11);
    chk("t2 p1 b4",  32'(obytes[192]), 32'hB8);
    chk("t2 n b1",   32'(obytes[377]), 32'h1F);
    chk("t2 n b2",   32'(obytes[378]), 32'hFF);
    chk("t2 n b3",   32'(obytes[379]), 32'h10);
    chk("t2 n b100", 32'(obytes[476]), 32'hFF);
    chk("t2 n flag", 32'(onull[376]),  32'd1);
    chk("t2 d flag", 32'(onull[0]),    32'd0);

    // 3: starved -> null; data arriving mid-null does not convert it
    do_reset();
    push_n(100, 0, 0);
    clear_capture();
    @(negedge clk); tx_en = 1;
    repeat (20) @(negedge clk);
    push_n(84, 100, 0);
    wait_bytes(376, 600);
    tx_en = 0;
    chk("t3 n b1",   32'(obytes[1]),   32'h1F);
    chk("t3 n b187", 32'(obytes[187]), 32'hFF);
    chk("t3 n flag", 32'(onull[187]),  32'd1);
    chk("t3 d b0",   32'(obytes[188]), 32'h47);
    chk("t3 d b1",   32'(obytes[189]), 32'h01);
    chk("t3 d cc",   32'(obytes[191]), 32'h10);
    chk("t3 d b4",   32'(obytes[192]), 32'h00);
    chk("t3 d flag", 32'(onull[188]),  32'd0);

    // 4: 17 data packets, CC wraps
    do_reset();
    push_n(368, 0, 0);
    clear_capture();
    @(negedge clk); tx_en = 1;
    push_n(3128 - 368, 368, 0);
    wait_bytes(17 * 188, 2000);
    tx_en = 0;
    for (int k = 0; k < 17; k++) begin
      chk("t4 sync", 32'(obytes[188*k]),     32'h47);
      chk("t4 cc",   32'(obytes[188*k + 3]), 32'h10 | 32'(k % 16));
    end

    // 5: gapped tx_en, full FIFO, push/pop at the same time
    do_reset();
    push_n(184, 0, 0);
    clear_capture();
    for (int i = 0; i < 376; i++) begin
      @(negedge clk); tx_en = (i % 2 == 0);
    end
    @(negedge clk); tx_en = 0;
    repeat (2) @(negedge clk);
    chk("t5 count", 32'(obytes.size()), 32'd188);
    chk("t5 b4",    32'(obytes[4]),     32'h00);
    chk("t5 b187",  32'(obytes[187]),   32'hB7);
    push_n(DEPTH, 0, 0);
    chk("t5 full level", 32'(level),        32'd512);
    chk("t5 full ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); tx_en = 1; bus.in_valid = 1; bus.in_byte = 8'(i);
    end
    @(negedge clk); tx_en = 0; bus.in_valid = 0;
    chk("t5 hold level", 32'(level), 32'd511);

    // 6: reset mid-packet; NULL_EN=0 stays silent when starved
    do_reset();
    clear_capture();
    acc = 0; guard = 0;
    while (acc < 184 && guard < 1000) begin
      @(negedge clk);
      bus2.in_valid = 1; bus2.in_byte = 8'(acc); bus2.in_start = (acc == 0);
      if (bus2.in_ready) acc++;
      guard++;
    end
    @(negedge clk); bus2.in_valid = 0; bus2.in_start = 0;
    chk("t6 push", 32'(acc), 32'd184);
    tx_en2 = 1;
    cnt = 0; guard = 0;
    while (cnt < 91 && guard < 400) begin
      @(negedge clk);
      if (bus2.byte_valid) cnt++;
      guard++;
    end
    chk("t6 reached bcnt90", 32'(cnt), 32'd91);
    #2 rst = 0;
    #1;
    chk("t6 rst valid",  32'(bus2.byte_valid), 32'd0);
    chk("t6 rst byte",   32'(bus2.byte_out),   32'd0);
    chk("t6 rst sop",    32'(bus2.sop),        32'd0);
    chk("t6 rst level",  32'(level2),          32'd0);
    chk("t6 rst ready",  32'(bus2.in_ready),   32'd0);
    chk("t6 b0",   32'(obytes2[0]),  32'h47);
    chk("t6 b1",   32'(obytes2[1]),  32'h41);
    chk("t6 b90",  32'(obytes2[90]), 32'h56);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus2.byte_valid) cnt++;
    end
    tx_en2 = 0;
    chk("t6 starved silent", 32'(cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ts_packet_tx.md
Name: ts_packet_tx

Overview:
MPEG2-TS packet transmitter, the sending end of the per-channel sync recovery path. It accepts elementary payload bytes over a valid/ready handshake and buffers them in an internal FIFO. It emits 188-byte transport packets (sync byte 0x47, 4-byte header, 184-byte payload) one byte per tx_en strobe. When fewer than 184 payload bytes are buffered at a packet boundary, it inserts null packets so the output stream stays continuous and the downstream receiver keeps lock.

Parameters:
PID, 13'h0100, PID placed in every data packet header
FIFO_DEPTH, 512, payload FIFO entries (power of 2, >= 368)
NULL_EN, 1, 1 = insert null packets when starved; 0 = stay idle when starved

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
tx_en  input  1  output pacing strobe; one output byte per asserted cycle
in_byte  input  8  payload byte
in_start  input  1  marks in_byte as first byte of a PES unit (drives PUSI)
in_valid  input  1  in_byte/in_start valid
in_ready  output  1  FIFO can accept; transfer when in_valid & in_ready
byte_out  output  8  TS byte
byte_valid  output  1  byte_out valid, one cycle per emitted byte
sop  output  1  high with byte_valid on byte 0 (0x47) of each packet
fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
null_pkt  output  1  high while the packet being emitted is a null packet

Behaviour:
- Reset (async, rst=0): byte_out=0, byte_valid=0, sop=0, null_pkt=0, in_ready=0 while in reset then 1, fifo_level=0, CC=0, byte counter=0, state IDLE. Reset mid-packet truncates the packet. No resumption.
- FIFO: 9-bit entries {in_start, in_byte}. in_ready = (fifo_level < FIFO_DEPTH). A push and a pop in the same cycle leave the level unchanged. Pop only during data-payload bytes.
- Output registered: a byte selected on a tx_en cycle appears on byte_out with byte_valid=1 on the next cycle. In cycles following tx_en=0: byte_valid=0, sop=0, byte_out=0.
- Byte counter bcnt 0..187, advances only on tx_en while a packet is in progress, wraps 187->0.
- FSM states: IDLE, HDR, DATA, NULL.
- IDLE, on tx_en:
  - if fifo_level >= 184: go to HDR (data packet) and emit 0x47 with sop.
  - else if NULL_EN: go to HDR (null packet) and emit 0x47 with sop.
  - else: emit nothing and re-evaluate on the next tx_en.
  - The decision is latched for the whole packet. Bytes pushed during a null packet do not convert it.
- HDR, data packet, bcnt 1..3:
  - byte1 = {1'b0, PUSI, 1'b0, PID[12:8]}, where PUSI = in_start flag of the FIFO head entry (peek, no pop).
  - byte2 = PID[7:0].
  - byte3 = {2'b00, 2'b01, CC}.
  - Then go to DATA.
- HDR, null packet: bytes 0x1F, 0xFF, 0x10. Then go to NULL.
- DATA, bcnt 4..187: byte = FIFO head[7:0], pop on each tx_en. The 184 entries are guaranteed by the IDLE check. In_start flags of non-head bytes are dropped.
- NULL, bcnt 4..187: byte = 0xFF.
- After bcnt 187 on tx_en, return to IDLE. Back-to-back packets are allowed: the IDLE decision is made on the next tx_en, so there are no gap bytes beyond tx_en pacing.
- CC: 4-bit, increments modulo 16 after each completed data packet, wraps 15->0. Null packets always carry CC 0 and do not affect CC.
- null_pkt: high from sop through byte 187 of a null packet.

Test Plan:
1. Reset, then push 184 bytes 0x00..0xB7 with the first in_start=1, tx_en continuous -> 47 41 00 10, then 00..B7, sop on the first byte, fifo_level back to 0.
2. Push 368 bytes, no in_start, tx_en continuous -> two packets with headers 47 01 00 10 and 47 01 00 11, then null packets (47 1F FF 10, 184 x FF) with null_pkt=1.
3. NULL_EN=1, FIFO holds 100 bytes, tx_en continuous -> null packet emitted. Push 84 more mid-packet -> the null packet completes unchanged, the next packet is data with CC=0.
4. 17 consecutive data packets -> CC sequence 0..15,0.
5. tx_en toggling 1-0-1-0 -> byte_valid follows one cycle later, bytes never skipped or duplicated. Fill to FIFO_DEPTH -> in_ready=0; simultaneous push/pop holds the level.
6. Assert rst at bcnt=90 of a data packet -> outputs 0 immediately, FIFO empty. After release, with NULL_EN=0 and no input, byte_valid stays 0.
